// File: rtl/alu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// alu_ctrl_seq
//
// Decodes ALU control from {ALUOp, funct7, funct3} behind a valid/ready
// handshake. Non-MUL results are presented one cycle after acceptance.
// MUL results are presented MUL_LAT cycles after acceptance, modelling the
// latency of a multi-cycle multiplier.
//
// Handshake: a request transfers on a rising edge where valid_i & ready_o.
// A result transfers on a rising edge where valid_o & ready_i. While valid_o
// is high, ALUCtrl_o/err_o are held stable until the result is taken.
//
// Ports
//   clk_i      in   1   clock, rising edge
//   rst_i      in   1   asynchronous reset, active low
//   valid_i    in   1   upstream request offered
//   ready_o    out  1   request can be accepted this cycle
//   ALUOp_i    in   2   main-control op class
//   funct_i    in   10  {funct7[6:0], funct3[2:0]}
//   valid_o    out  1   ALUCtrl_o/err_o hold a decoded result
//   ready_i    in   1   downstream takes the result
//   ALUCtrl_o  out  3   AND 000, OR 001, ADD 010, MUL 011, SUB 110, SLT 111
//   err_o      out  1   result came from an undecodable request (op = ADD)
//   busy_o     out  1   MUL in progress
//   state_o    out  2   FSM state for observation: IDLE 0, MULW 1, HOLD 2
// ---------------------------------------------------------------------------
module alu_ctrl_seq #(
   parameter int MUL_LAT = 3
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       valid_i,
   output logic       ready_o,
   input  logic [1:0] ALUOp_i,
   input  logic [9:0] funct_i,
   output logic       valid_o,
   input  logic       ready_i,
   output logic [2:0] ALUCtrl_o,
   output logic       err_o,
   output logic       busy_o,
   output logic [1:0] state_o
);

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   // MULW is entered after the accepting edge and left at the edge where the
   // counter reads zero, so loading MUL_LAT-2 gives MUL_LAT edges in total.
   localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 2);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULW = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [2:0] ctrl, ctrl_nxt;
   logic       err, err_nxt;

   logic [2:0] dec_ctrl;
   logic       dec_err;
   logic       accept;

   // ------------------------------------------------------------------
   // Combinational decode of the request currently on the inputs
   // ------------------------------------------------------------------
   always_comb begin
      dec_ctrl = OP_ADD;
      dec_err  = 1'b0;
      unique case (ALUOp_i)
         2'b00: dec_ctrl = OP_ADD;
         2'b01: dec_ctrl = OP_SUB;
         2'b10: begin
            case (funct_i)
               10'b0000000_000: dec_ctrl = OP_ADD;
               10'b0100000_000: dec_ctrl = OP_SUB;
               10'b0000000_111: dec_ctrl = OP_AND;
               10'b0000000_110: dec_ctrl = OP_OR;
               10'b0000000_010: dec_ctrl = OP_SLT;
               10'b0000001_000: dec_ctrl = OP_MUL;
               default: begin
                  dec_ctrl = OP_ADD;
                  dec_err  = 1'b1;
               end
            endcase
         end
         2'b11: begin
            // I-type: funct7 carries immediate bits, only funct3 matters
            case (funct_i[2:0])
               3'b000:  dec_ctrl = OP_ADD;
               3'b111:  dec_ctrl = OP_AND;
               3'b110:  dec_ctrl = OP_OR;
               3'b010:  dec_ctrl = OP_SLT;
               default: begin
                  dec_ctrl = OP_ADD;
                  dec_err  = 1'b1;
               end
            endcase
         end
         default: begin
            dec_ctrl = OP_ADD;
            dec_err  = 1'b1;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Handshake and status outputs
   // ------------------------------------------------------------------
   assign ready_o   = (state == IDLE) | ((state == HOLD) & ready_i);
   assign accept    = valid_i & ready_o;
   assign valid_o   = (state == HOLD);
   assign busy_o    = (state == MULW);
   assign ALUCtrl_o = ctrl;
   assign err_o     = err;
   assign state_o   = state;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ctrl_nxt  = ctrl;
      err_nxt   = err;

      unique case (state)
         IDLE, HOLD: begin
            if (accept) begin
               ctrl_nxt = dec_ctrl;
               err_nxt  = dec_err;
               if (dec_ctrl == OP_MUL) begin
                  state_nxt = MULW;
                  cnt_nxt   = CNT_LOAD;
               end else begin
                  state_nxt = HOLD;
               end
            end else if ((state == HOLD) && ready_i) begin
               // result taken with nothing new offered
               state_nxt = IDLE;
            end
         end
         MULW: begin
            if (cnt == 4'd0) begin
               state_nxt = HOLD;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= IDLE;
         cnt   <= 4'd0;
         ctrl  <= OP_ADD;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         ctrl  <= ctrl_nxt;
         err   <= err_nxt;
      end
   end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_ctrl_seq
//
// Directed-vector bench for alu_ctrl_seq (MUL_LAT = 3). Inputs are driven and
// outputs sampled 1 time unit after the rising edge; expected values are
// written out by hand for each vector.
// ---------------------------------------------------------------------------
module tb_alu_ctrl_seq;

   logic       clk_i;
   logic       rst_i;
   logic       valid_i;
   logic       ready_o;
   logic [1:0] ALUOp_i;
   logic [9:0] funct_i;
   logic       valid_o;
   logic       ready_i;
   logic [2:0] ALUCtrl_o;
   logic       err_o;
   logic       busy_o;
   logic [1:0] state_o;

   int checks;
   int failures;

   alu_ctrl_seq #(.MUL_LAT(3)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .ALUOp_i  (ALUOp_i),
      .funct_i  (funct_i),
      .valid_o  (valid_o),
      .ready_i  (ready_i),
      .ALUCtrl_o(ALUCtrl_o),
      .err_o    (err_o),
      .busy_o   (busy_o),
      .state_o  (state_o)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] op,
                        input logic [9:0] fn, input logic rdy);
      valid_i = v;
      ALUOp_i = op;
      funct_i = fn;
      ready_i = rdy;
      #1;
   endtask

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic v, input logic [2:0] c,
                            input logic e, input logic b);
      check({tag, ".valid"}, 32'(valid_o), 32'(v));
      check({tag, ".ctrl"},  32'(ALUCtrl_o), 32'(c));
      check({tag, ".err"},   32'(err_o), 32'(e));
      check({tag, ".busy"},  32'(busy_o), 32'(b));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      checks   = 0;
      failures = 0;
      rst_i    = 1'b0;
      valid_i  = 1'b0;
      ALUOp_i  = 2'b00;
      funct_i  = 10'd0;
      ready_i  = 1'b0;

      // reset state
      step();
      step();
      check_out("rst", 1'b0, 3'b010, 1'b0, 1'b0);
      check("rst.ready", 32'(ready_o), 32'd1);
      check("rst.state", 32'(state_o), 32'd0);
      rst_i = 1'b1;

      // R-type SUB, latency 1
      drive(1'b1, 2'b10, 10'b0100000_000, 1'b1);
      check("sub.ready", 32'(ready_o), 32'd1);
      step();
      check_out("sub", 1'b1, 3'b110, 1'b0, 1'b0);
      drive(1'b0, 2'b00, 10'd0, 1'b1);
      step();
      check_out("sub_ret", 1'b0, 3'b110, 1'b0, 1'b0);

      // MUL, latency 3; ready_i stays high to show it has no effect in MULW
      drive(1'b1, 2'b10, 10'b0000001_000, 1'b1);
      step();
      drive(1'b1, 2'b00, 10'd0, 1'b1);
      check_out("mul1", 1'b0, 3'b011, 1'b0, 1'b1);
      check("mul1.ready", 32'(ready_o), 32'd0);
      check("mul1.state", 32'(state_o), 32'd1);
      step();
      check_out("mul2", 1'b0, 3'b011, 1'b0, 1'b1);
      check("mul2.ready", 32'(ready_o), 32'd0);
      drive(1'b0, 2'b00, 10'd0, 1'b0);
      step();
      check_out("mul3", 1'b1, 3'b011, 1'b0, 1'b0);
      step();
      check_out("mul_hold", 1'b1, 3'b011, 1'b0, 1'b0);
      drive(1'b0, 2'b00, 10'd0, 1'b1);
      step();
      check_out("mul_ret", 1'b0, 3'b011, 1'b0, 1'b0);

      // back-to-back stream ADD, AND, SLT
      drive(1'b1, 2'b10, 10'b0000000_000, 1'b1);
      step();
      check_out("s_add", 1'b1, 3'b010, 1'b0, 1'b0);
      drive(1'b1, 2'b10, 10'b0000000_111, 1'b1);
      check("s_and.ready", 32'(ready_o), 32'd1);
      step();
      check_out("s_and", 1'b1, 3'b000, 1'b0, 1'b0);
      drive(1'b1, 2'b10, 10'b0000000_010, 1'b1);
      step();
      check_out("s_slt", 1'b1, 3'b111, 1'b0, 1'b0);
      drive(1'b0, 2'b00, 10'd0, 1'b1);
      step();
      check("s_end.valid", 32'(valid_o), 32'd0);

      // I-type OR with funct7 garbage, then a 4-cycle stall offering SUB
      drive(1'b1, 2'b11, 10'b1010101_110, 1'b0);
      step();
      check_out("i_or", 1'b1, 3'b001, 1'b0, 1'b0);
      drive(1'b1, 2'b01, 10'h3ff, 1'b0);
      for (int i = 0; i < 4; i++) begin
         check("stall.ready", 32'(ready_o), 32'd0);
         check_out("stall", 1'b1, 3'b001, 1'b0, 1'b0);
         step();
      end
      drive(1'b1, 2'b01, 10'h3ff, 1'b1);
      check("unstall.ready", 32'(ready_o), 32'd1);
      step();
      check_out("op01_sub", 1'b1, 3'b110, 1'b0, 1'b0);
      drive(1'b1, 2'b00, 10'h3ff, 1'b1);
      step();
      check_out("op00_add", 1'b1, 3'b010, 1'b0, 1'b0);

      // undecodable requests, then a legal one clears err_o
      drive(1'b1, 2'b10, 10'b1111111_101, 1'b1);
      step();
      check_out("r_err", 1'b1, 3'b010, 1'b1, 1'b0);
      drive(1'b1, 2'b11, 10'b0000000_001, 1'b1);
      step();
      check_out("i_err", 1'b1, 3'b010, 1'b1, 1'b0);
      drive(1'b1, 2'b11, 10'b0000000_111, 1'b1);
      step();
      check_out("i_and", 1'b1, 3'b000, 1'b0, 1'b0);
      drive(1'b0, 2'b00, 10'd0, 1'b1);
      step();

      // reset mid-MULW, asynchronous, no stale valid afterwards
      drive(1'b1, 2'b10, 10'b0000001_000, 1'b1);
      step();
      drive(1'b0, 2'b00, 10'd0, 1'b1);
      check_out("pre_rst", 1'b0, 3'b011, 1'b0, 1'b1);
      rst_i = 1'b0;
      #1;
      check_out("async_rst", 1'b0, 3'b010, 1'b0, 1'b0);
      step();
      step();
      rst_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("post_rst.valid", 32'(valid_o), 32'd0);
         check("post_rst.busy", 32'(busy_o), 32'd0);
      end

      // first edge after release accepts
      rst_i = 1'b0;
      step();
      rst_i = 1'b1;
      drive(1'b1, 2'b10, 10'b0000000_110, 1'b1);
      step();
      check_out("first_acc", 1'b1, 3'b001, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_ctrl_seq.md
ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

Interface
REQ-001 SHALL have parameter MUL_LAT, default 3, cycles from acceptance to valid_o for a MUL op (legal range 2..15).
REQ-002 SHALL have port clk_i  input  1  single clock, all state changes on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port valid_i  input  1  upstream offers an instruction decode request.
REQ-005 SHALL have port ready_o  output  1  block can accept a request this cycle.
REQ-006 SHALL have port ALUOp_i  input  2  main-control op class.
REQ-007 SHALL have port funct_i  input  10  {funct7[6:0], funct3[2:0]}.
REQ-008 SHALL have port valid_o  output  1  ALUCtrl_o/err_o hold a decoded result.
REQ-009 SHALL have port ready_i  input  1  downstream ALU stage takes the result.
REQ-010 SHALL have port ALUCtrl_o  output  3  ALU op code: AND 000, OR 001, ADD 010, MUL 011, SUB 110, SLT 111.
REQ-011 SHALL have port err_o  output  1  result came from an undecodable request (ALUCtrl_o forced to ADD).
REQ-012 SHALL have port busy_o  output  1  multi-cycle MUL in progress.

Function
REQ-013 SHALL decode ALUOp 00 -> ADD, 01 -> SUB, regardless of funct_i.
REQ-014 SHALL decode ALUOp 10 (R-type) by full funct_i: 0000000_000 ADD, 0100000_000 SUB, 0000000_111 AND, 0000000_110 OR, 0000000_010 SLT, 0000001_000 MUL.
REQ-015 SHALL decode ALUOp 11 (I-type) by funct3 only: 000 ADD, 111 AND, 110 OR, 010 SLT; funct7 ignored.
REQ-016 SHALL decode any other combination as ADD with err_o=1; err_o SHALL be 0 for all legal codes.
REQ-017 SHALL implement states IDLE, MULW, HOLD.
REQ-018 SHALL drive ready_o = (state==IDLE) | (state==HOLD & ready_i), combinationally.
REQ-019 SHALL accept a request at a rising edge where valid_i & ready_o, capturing decode into ALUCtrl_o/err_o registers at that edge.
REQ-020 Non-MUL accept SHALL go to HOLD: valid_o high in the cycle after the accepting edge (latency 1).
REQ-021 MUL accept SHALL go to MULW with counter loaded MUL_LAT-2; decrement each cycle; at counter 0 go to HOLD; valid_o first high exactly MUL_LAT cycles after the accepting edge.
REQ-022 busy_o SHALL be 1 exactly in MULW; valid_o SHALL be 0 in IDLE and MULW, 1 in HOLD.
REQ-023 In HOLD with ready_i=0, ALUCtrl_o, err_o, valid_o SHALL remain stable; valid_i ignored.
REQ-024 In HOLD with ready_i=1 and valid_i=1, SHALL retire the current result and accept the new one in the same edge (back-to-back, no bubble for non-MUL).
REQ-025 In HOLD with ready_i=1 and valid_i=0, SHALL return to IDLE.
REQ-026 In MULW, ready_o SHALL be 0 and ready_i SHALL have no effect.
REQ-027 ALUCtrl_o and err_o SHALL change only at an accepting edge or reset.

Reset
REQ-028 rst_i low SHALL immediately force state IDLE, counter 0, ALUCtrl_o=010 (ADD), err_o=0, valid_o=0, busy_o=0, independent of clk_i.
REQ-029 Reset asserted during MULW or HOLD SHALL discard the in-flight result with no valid_o pulse after release.
REQ-030 First acceptance SHALL be possible at the first rising edge after rst_i deasserts.

Verification
REQ-031 ALUOp=10, funct=0100000_000, valid_i=1, ready_i=1 -> next cycle valid_o=1, ALUCtrl_o=110, err_o=0, busy_o=0.
REQ-032 ALUOp=10, funct=0000001_000, MUL_LAT=3, accept at edge k -> busy_o=1 cycles k+1..k+2, ready_o=0 there, valid_o=1 with ALUCtrl_o=011 from cycle k+3.
REQ-033 Stream of three non-MUL requests (ADD, AND, SLT) with ready_i=1 -> valid_o continuously high for three cycles, ALUCtrl_o 010, 000, 111 in order.
REQ-034 Result in HOLD, ready_i=0 for 4 cycles while valid_i=1 with new op -> outputs unchanged, ready_o=0; ready_i=1 -> new op accepted that edge.
REQ-035 ALUOp=10, funct=1111111_101 -> valid_o=1, ALUCtrl_o=010, err_o=1; following legal request clears err_o.
REQ-036 rst_i pulled low mid-MULW -> valid_o, busy_o go 0 without clock edge, ALUCtrl_o=010; no valid_o after release until a new acceptance.
